arbitro_rr_4x2: RTL and testbench
=================================

// Module: arbitro_rr_4x2
// PURPOSE
//  Round-robin scheduler sharing four 8-bit input FIFOs (lanes 0-3) onto two output lanes (00, 11).
//  Each clk_f cycle it picks up to two non-empty FIFOs, issues their pops, and steers returned words
//  to data_00/data_11 with valid flags. It honours almost-full backpressure from the two downstream FIFOs.
//  It sits between the per-lane input FIFOs and the 4-to-2 lane datapath, replacing fixed lane pairing.
// PARAMETERS
//  DATA_W   8   word width per lane
//  CNT_W    16  width of optional per-output word counters
// PORTS
//  clk_f       in   1         single clock, all logic on posedge
//  reset       in   1         asynchronous, active-high; clears all state
//  enable      in   1         1 = scheduling allowed
//  fifo_empty  in   4         bit i = input FIFO i empty
//  fifo_data   in   4*DATA_W  {d3,d2,d1,d0}; FIFO read data, valid the cycle after its pop
//  out_afull   in   2         bit0 = downstream FIFO of lane 00 almost full, bit1 = lane 11
//  pop         out  4         bit i pops FIFO i (combinational from state + inputs)
//  data_00     out  DATA_W    output lane 00 word (registered)
//  valid_00    out  1         data_00 valid
//  data_11     out  DATA_W    output lane 11 word (registered)
//  valid_11    out  1         data_11 valid
//  state_o     out  2         current FSM state
//  cnt_00/11   out  CNT_W     words delivered per lane (only with ARB_COUNT_EN)
// BEHAVIOUR
//  Reset (async, high): state=IDLE, rr_ptr=0, in-flight selects cleared, pop=0,
//   data_00=data_11=0, valid_00=valid_11=0, counters=0. Reset mid-operation discards in-flight words.
//  FSM: IDLE->ACTIVE when enable=1. ACTIVE->PAUSE when out_afull!=0. PAUSE->ACTIVE when out_afull==0.
//   ACTIVE/PAUSE->IDLE when enable=0. Transitions take effect on the next edge.
//  Pops only when state==ACTIVE && enable && out_afull==0 (same-cycle gating, no extra latency).
//  Pick: scan i = rr_ptr, rr_ptr+1, ... (mod 4); first non-empty -> lane 00, second -> lane 11.
//   At most 2 pops per cycle; never pops an empty FIFO.
//   rr_ptr <= (last granted index + 1) mod 4; unchanged when nothing granted.
//   Exactly one grant -> lane 00 only; lane 11 invalid that cycle.
//  Pipeline: pop in cycle N; select + grant flags registered at end of N; fifo_data muxed in N+1;
//   data/valid registered at end of N+1 -> visible cycle N+2. Latency pop->valid = 2 cycles, fixed.
//  In-flight words always complete after leaving ACTIVE (enable drop or afull); only reset drops them.
//  Ungranted lane: valid=0, data=0.
//  Downstream FIFOs must assert almost-full with >= 2 free entries (2 words in flight per lane).
//  Each word delivered exactly once, order per input FIFO preserved.
// CONFIGURATION
//  `ARB_COUNT_EN defined: cnt_00/cnt_11 increment on each cycle valid_00/valid_11 is 1;
//   wrap from 2^CNT_W-1 to 0; cleared only by reset.
//  Not defined: ports cnt_00/cnt_11 absent, no counter logic.
// STRUCTURE
//  Shared header arbitro_defs.vh: state localparams ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_PAUSE=2'd2,
//   N_IN=4, lane index width 2.
//  Sub-module arbitro_rr_pick2: combinational; inputs fifo_empty, rr_ptr, go; outputs pop[3:0],
//   sel_00[1:0], sel_11[1:0], gnt_00, gnt_11, next_ptr. Top holds FSM, pointer, pipeline, counters.
// TESTING
//  T1 reset: assert reset mid-stream with 2 words in flight -> all outputs 0 immediately, state=IDLE,
//     no valid after release until new pops.
//  T2 all full, rr_ptr=0, enable=1: cycle1 pop=4'b0011, cycle2 pop=4'b1100, cycle3 pop=4'b0011;
//     lane00 gets d0,d2,d0..., lane11 gets d1,d3,d1..., each 2 cycles after its pop.
//  T3 only FIFO 2 non-empty (3 words 0xA1,0xA2,0xA3): pop=4'b0100 three cycles; data_00 = A1,A2,A3,
//     valid_11 stays 0.
//  T4 out_afull=2'b10 during streaming: pop=0 same cycle, state=PAUSE next edge, 2 in-flight
//     words still emerge; clear afull -> ACTIVE, pops resume from saved rr_ptr.
//  T5 enable=0 mid-stream -> state IDLE, pop=0; outstanding words delivered; no duplicates/loss
//     versus scoreboard of popped values.
//  T6 (ARB_COUNT_EN, CNT_W=4) 18 words to lane 00 -> cnt_00=2 after wrap; without macro, build clean.

Source files
------------

// File: rtl/arbitro_rr_4x2_pkg.sv
// Shared types and constants for the 4-to-2 round-robin lane scheduler.
package arbitro_rr_4x2_pkg;

    localparam int N_IN   = 4;
    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro_rr_pick2.sv
// Combinational round-robin picker: grants up to two non-empty FIFOs per cycle,
// first found to lane 00 and second to lane 11, scanning from rr_ptr.
module arbitro_rr_pick2
    import arbitro_rr_4x2_pkg::*;
(
    input  logic [N_IN-1:0]   fifo_empty,
    input  logic [LANE_W-1:0] rr_ptr,
    input  logic              go,
    output logic [N_IN-1:0]   pop,
    output logic [LANE_W-1:0] sel_00,
    output logic [LANE_W-1:0] sel_11,
    output logic              gnt_00,
    output logic              gnt_11,
    output logic [LANE_W-1:0] next_ptr
);

    logic [LANE_W-1:0] idx;

    always_comb begin
        pop      = '0;
        sel_00   = '0;
        sel_11   = '0;
        gnt_00   = 1'b0;
        gnt_11   = 1'b0;
        next_ptr = rr_ptr;
        idx      = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = rr_ptr + LANE_W'(k);
            if (go && !fifo_empty[idx]) begin
                if (!gnt_00) begin
                    gnt_00   = 1'b1;
                    sel_00   = idx;
                    pop[idx] = 1'b1;
                    next_ptr = idx + LANE_W'(1);
                end else if (!gnt_11) begin
                    gnt_11   = 1'b1;
                    sel_11   = idx;
                    pop[idx] = 1'b1;
                    next_ptr = idx + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4x2.sv
// Round-robin scheduler moving words from four input FIFOs onto two output lanes.
// Optional per-lane delivered-word counters are built when ARB_COUNT_EN is defined.
module arbitro_rr_4x2
    import arbitro_rr_4x2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_IN-1:0]        fifo_empty,
    input  logic [N_IN*DATA_W-1:0] fifo_data,
    input  logic [1:0]             out_afull,
    output logic [N_IN-1:0]        pop,
    output logic [DATA_W-1:0]      data_00,
    output logic                   valid_00,
    output logic [DATA_W-1:0]      data_11,
    output logic                   valid_11,
`ifdef ARB_COUNT_EN
    output logic [CNT_W-1:0]       cnt_00,
    output logic [CNT_W-1:0]       cnt_11,
`endif
    output logic [1:0]             state_o
);

    state_t            state;
    logic [LANE_W-1:0] rr_ptr;
    logic              go;

    logic [LANE_W-1:0] sel_00_p0, sel_11_p0, next_ptr_p0;
    logic              gnt_00_p0, gnt_11_p0;

    logic [LANE_W-1:0] sel_00_p1, sel_11_p1;
    logic              vld_00_p1, vld_11_p1;

    logic [DATA_W-1:0] words [N_IN];

    // Pops are gated in the same cycle the downstream or enable condition changes.
    assign go      = (state == ST_ACTIVE) && enable && (out_afull == 2'b00);
    assign state_o = state;

    arbitro_rr_pick2 u_pick (
        .fifo_empty (fifo_empty),
        .rr_ptr     (rr_ptr),
        .go         (go),
        .pop        (pop),
        .sel_00     (sel_00_p0),
        .sel_11     (sel_11_p0),
        .gnt_00     (gnt_00_p0),
        .gnt_11     (gnt_11_p0),
        .next_ptr   (next_ptr_p0)
    );

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
        end else begin
            rr_ptr <= next_ptr_p0;
            case (state)
                ST_IDLE:   if (enable) state <= ST_ACTIVE;
                ST_ACTIVE: begin
                    if (!enable)                  state <= ST_IDLE;
                    else if (out_afull != 2'b00)  state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!enable)                  state <= ST_IDLE;
                    else if (out_afull == 2'b00)  state <= ST_ACTIVE;
                end
                default:                          state <= ST_IDLE;
            endcase
        end
    end

    // p0 -> p1: remember which FIFO each lane popped; its word arrives next cycle.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            sel_00_p1 <= '0;
            sel_11_p1 <= '0;
            vld_00_p1 <= 1'b0;
            vld_11_p1 <= 1'b0;
        end else begin
            sel_00_p1 <= sel_00_p0;
            sel_11_p1 <= sel_11_p0;
            vld_00_p1 <= gnt_00_p0;
            vld_11_p1 <= gnt_11_p0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            words[i] = fifo_data[i*DATA_W +: DATA_W];
        end
    end

    // p1 -> output: steer returned FIFO words; idle lanes are forced to zero.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_00  <= '0;
            data_11  <= '0;
            valid_00 <= 1'b0;
            valid_11 <= 1'b0;
        end else begin
            data_00  <= vld_00_p1 ? words[sel_00_p1] : '0;
            data_11  <= vld_11_p1 ? words[sel_11_p1] : '0;
            valid_00 <= vld_00_p1;
            valid_11 <= vld_11_p1;
        end
    end

`ifdef ARB_COUNT_EN
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            cnt_00 <= '0;
            cnt_11 <= '0;
        end else begin
            if (valid_00) cnt_00 <= cnt_00 + CNT_W'(1);
            if (valid_11) cnt_11 <= cnt_11 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr_4x2.sv
// Randomized bench for arbitro_rr_4x2: input FIFOs and the scheduling rules are modelled
// with queues and timestamped expectations; counters are checked when ARB_COUNT_EN is set.
module tb_arbitro_rr_4x2;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk_f = 1'b0;
    logic              reset;
    logic              enable;
    logic [3:0]        fifo_empty;
    logic [4*DATA_W-1:0] fifo_data;
    logic [1:0]        out_afull;
    logic [3:0]        pop;
    logic [DATA_W-1:0] data_00, data_11;
    logic              valid_00, valid_11;
    logic [1:0]        state_o;
`ifdef ARB_COUNT_EN
    logic [CNT_W-1:0]  cnt_00, cnt_11;
`endif

    arbitro_rr_4x2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .out_afull  (out_afull),
        .pop        (pop),
        .data_00    (data_00),
        .valid_00   (valid_00),
        .data_11    (data_11),
        .valid_11   (valid_11),
`ifdef ARB_COUNT_EN
        .cnt_00     (cnt_00),
        .cnt_11     (cnt_11),
`endif
        .state_o    (state_o)
    );

    always #5 clk_f = ~clk_f;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: contents of the input FIFOs, scheduler mode/pointer,
    // and for each output lane the (cycle, word) pairs it must show.
    int q[4][$];
    int e00_t[$], e00_d[$], e11_t[$], e11_d[$];
    int mstate, mptr, cyc;
    int mcnt00, mcnt11;
    logic [3:0] last_pop;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (q[i].size() == 0);
    endtask

    task automatic fill(input int i, input int n);
        for (int k = 0; k < n; k++) q[i].push_back(int'($urandom_range(0, 255)));
    endtask

    task automatic check_outputs();
        int ev0, ed0, ev1, ed1;
        ev0 = 0; ed0 = 0; ev1 = 0; ed1 = 0;
        if (e00_t.size() > 0 && e00_t[0] == cyc) begin
            ev0 = 1; ed0 = e00_d[0];
            void'(e00_t.pop_front()); void'(e00_d.pop_front());
        end
        if (e11_t.size() > 0 && e11_t[0] == cyc) begin
            ev1 = 1; ed1 = e11_d[0];
            void'(e11_t.pop_front()); void'(e11_d.pop_front());
        end
        check_val("valid_00", 32'(valid_00), ev0);
        check_val("data_00",  32'(data_00),  ed0);
        check_val("valid_11", 32'(valid_11), ev1);
        check_val("data_11",  32'(data_11),  ed1);
`ifdef ARB_COUNT_EN
        check_val("cnt_00", 32'(cnt_00), mcnt00 % (1 << CNT_W));
        check_val("cnt_11", 32'(cnt_11), mcnt11 % (1 << CNT_W));
`endif
        mcnt00 += ev0;
        mcnt11 += ev1;
    endtask

    task automatic run_cycle();
        logic [3:0] ep;
        int n, last, i, ns;
        int w[4];
        @(negedge clk_f);
        ep = '0; n = 0; last = -1;
        for (int k = 0; k < 4; k++) w[k] = 0;
        if (mstate == 1 && enable && out_afull == 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                i = (mptr + k) % 4;
                if (q[i].size() > 0 && n < 2) begin
                    ep[i] = 1'b1;
                    w[i] = q[i].pop_front();
                    if (n == 0) begin e00_t.push_back(cyc + 2); e00_d.push_back(w[i]); end
                    else        begin e11_t.push_back(cyc + 2); e11_d.push_back(w[i]); end
                    n++;
                    last = i;
                end
            end
        end
        check_val("pop", 32'(pop), 32'(ep));
        last_pop = pop;
        check_val("state", 32'(state_o), mstate);
        check_outputs();
        ns = mstate;
        case (mstate)
            0: if (enable) ns = 1;
            1: if (!enable) ns = 0; else if (out_afull != 2'b00) ns = 2;
            2: if (!enable) ns = 0; else if (out_afull == 2'b00) ns = 1;
            default: ns = 0;
        endcase
        mstate = ns;
        if (last >= 0) mptr = (last + 1) % 4;
        @(posedge clk_f);
        #1;
        cyc++;
        // Popped FIFOs present their word now; the rest show junk that must never be used.
        for (int k = 0; k < 4; k++)
            fifo_data[k*DATA_W +: DATA_W] = ep[k] ? 8'(w[k]) : 8'($urandom_range(0, 255));
        refresh_empty();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid_00"}, 32'(valid_00), 0);
        check_val({tag, "_data_00"},  32'(data_00),  0);
        check_val({tag, "_valid_11"}, 32'(valid_11), 0);
        check_val({tag, "_data_11"},  32'(data_11),  0);
        check_val({tag, "_state"},    32'(state_o),  0);
        check_val({tag, "_pop"},      32'(pop),      0);
`ifdef ARB_COUNT_EN
        check_val({tag, "_cnt_00"}, 32'(cnt_00), 0);
        check_val({tag, "_cnt_11"}, 32'(cnt_11), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_f);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        e00_t.delete(); e00_d.delete(); e11_t.delete(); e11_d.delete();
        mstate = 0; mptr = 0; mcnt00 = 0; mcnt11 = 0;
        @(posedge clk_f);
        #1 reset = 1'b0;
        cyc++;
        refresh_empty();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; out_afull = 2'b00; fifo_data = '0;
        mstate = 0; mptr = 0; cyc = 0; mcnt00 = 0; mcnt11 = 0; last_pop = '0;
        refresh_empty();
        #12 check_reset_outputs("rst_init");
        @(posedge clk_f);
        #1 reset = 1'b0;

        // T2: all FIFOs loaded, pointer at 0: pairs {0,1} and {2,3} alternate.
        for (int i = 0; i < 4; i++) fill(i, 8);
        refresh_empty();
        enable = 1'b1;
        run_cycle();
        run_cycle(); check_val("t2_c1", 32'(last_pop), 32'h3);
        run_cycle(); check_val("t2_c2", 32'(last_pop), 32'hC);
        run_cycle(); check_val("t2_c3", 32'(last_pop), 32'h3);
        repeat (3) run_cycle();

        // T1: reset with words in flight; nothing may appear afterwards until new pops.
        do_reset();
        repeat (4) run_cycle();

        // T3: single non-empty FIFO feeds lane 00 only.
        enable = 1'b0;
        repeat (4) run_cycle();
        for (int i = 0; i < 4; i++) q[i].delete();
        q[2].push_back(32'hA1); q[2].push_back(32'hA2); q[2].push_back(32'hA3);
        refresh_empty();
        enable = 1'b1;
        run_cycle();
        run_cycle(); check_val("t3_pop", 32'(last_pop), 32'h4);
        repeat (5) run_cycle();

        // T4: downstream almost-full stops pops at once; in-flight words still land.
        for (int i = 0; i < 4; i++) fill(i, 6);
        refresh_empty();
        repeat (3) run_cycle();
        out_afull = 2'b10;
        run_cycle(); check_val("t4_pop_gated", 32'(last_pop), 32'h0);
        repeat (3) run_cycle();
        out_afull = 2'b00;
        repeat (4) run_cycle();

        // T5: enable drop mid-stream.
        enable = 1'b0;
        repeat (4) run_cycle();
        enable = 1'b1;
        repeat (4) run_cycle();

        // Random traffic with occasional backpressure, enable drops and resets.
        for (int c = 0; c < 1500; c++) begin
            enable    = ($urandom % 16) != 0;
            out_afull = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 6 && ($urandom % 2) == 1) fill(i, 1);
            refresh_empty();
            if (c % 400 == 399) do_reset();
            else                run_cycle();
        end

        // Drain: every expected word must have appeared.
        enable = 1'b0;
        out_afull = 2'b00;
        for (int i = 0; i < 4; i++) q[i].delete();
        refresh_empty();
        repeat (5) run_cycle();
        check_val("drain", e00_t.size() + e11_t.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
